anita3_buffer_dead_gen: RTL

Generates the 250 MHz `dead_i` level consumed by the deadtime counter. It tracks occupancy of the NBUF digitizer event buffers, enforces a fixed post-trigger digitization holdoff, and holds the instrument dead while the next buffer is occupied or the run is disabled. It also counts triggers that arrive while dead and latches that count on each PPS.

---
 rtl/anita3_buffer_dead_gen.sv | 118 +++++++++++
 1 files changed

// File: rtl/anita3_buffer_dead_gen.sv
// Dead-level generator for the 250 MHz deadtime counter: tracks event-buffer occupancy,
// runs the post-trigger holdoff, and (with ANITA3_LOST_TRIG_SCALER_EN) counts lost triggers per PPS.
`timescale 1ns/100ps
module anita3_buffer_dead_gen #(
    parameter int NBUF    = 4,
    parameter int HOLDOFF = 250
) (
    input  logic                    clk250_i,
    input  logic                    rst_n_i,
    input  logic                    trig_i,
    input  logic                    clear_i,
    input  logic [$clog2(NBUF)-1:0] clear_buf_i,
    input  logic                    disable_i,
    input  logic                    pps_i,
    output logic                    dead_o,
    output logic                    trig_accept_o,
    output logic [$clog2(NBUF)-1:0] buf_ptr_o,
    output logic [NBUF-1:0]         buf_full_o,
    output logic [15:0]             lost_scaler_o
);

    localparam int PW = $clog2(NBUF);
    localparam logic [15:0] HOLD_M1 = 16'(HOLDOFF - 1);

    typedef enum logic [1:0] {S_LIVE, S_DIGITIZE, S_FULL, S_DISABLED} state_e;

    state_e          state_q, state_d;
    logic [15:0]     hold_q, hold_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NBUF-1:0] full_q, full_d;
    logic            dead_q, acc_q;
    logic            accept, ptr_busy;

    always_comb begin
        accept   = (state_q == S_LIVE) && trig_i && !disable_i;
        ptr_busy = full_q[ptr_q];
        state_d  = state_q;
        hold_d   = hold_q;
        ptr_d    = ptr_q;
        full_d   = full_q;

        // Clear first so a coincident set of the same buffer wins.
        if (clear_i)
            full_d[clear_buf_i] = 1'b0;
        if (accept) begin
            full_d[ptr_q] = 1'b1;
            ptr_d         = ptr_q + 1'b1;
            hold_d        = HOLD_M1;
        end

        if (disable_i) begin
            state_d = S_DISABLED;
        end else begin
            case (state_q)
                S_LIVE:     if (accept) state_d = S_DIGITIZE;
                S_DIGITIZE: begin
                    if (hold_q == 16'd0)
                        state_d = ptr_busy ? S_FULL : S_LIVE;
                    else
                        hold_d = hold_q - 16'd1;
                end
                S_FULL:     if (!ptr_busy) state_d = S_LIVE;
                S_DISABLED: state_d = ptr_busy ? S_FULL : S_LIVE;
                default:    state_d = S_LIVE;
            endcase
        end
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_LIVE;
            hold_q  <= '0;
            ptr_q   <= '0;
            full_q  <= '0;
            dead_q  <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            full_q  <= full_d;
            dead_q  <= (state_d != S_LIVE);
            acc_q   <= accept;
        end
    end

    assign dead_o        = dead_q;
    assign trig_accept_o = acc_q;
    assign buf_ptr_o     = ptr_q;
    assign buf_full_o    = full_q;

`ifdef ANITA3_LOST_TRIG_SCALER_EN
    logic        lost;
    logic [15:0] lost_cnt_q, scaler_q;

    // Disable takes priority over loss: a trigger with disable_i high is never counted.
    assign lost = trig_i && !disable_i && (state_q == S_DIGITIZE || state_q == S_FULL);

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lost_cnt_q <= '0;
            scaler_q   <= '0;
        end else if (pps_i) begin
            scaler_q   <= lost_cnt_q;
            lost_cnt_q <= {15'd0, lost};
        end else if (lost && lost_cnt_q != 16'hFFFF) begin
            lost_cnt_q <= lost_cnt_q + 16'd1;
        end
    end

    assign lost_scaler_o = scaler_q;
`else
    logic unused_pps;
    assign unused_pps    = pps_i;
    assign lost_scaler_o = '0;
`endif

endmodule
